spi_regfile_slave: RTL and testbench



---
 rtl/spi_regfile_pkg.sv | 42 ++++
 rtl/spi_regfile_slave_if.sv | 17 +
 rtl/spi_regfile_mem.sv | 63 ++++++
 rtl/spi_regfile_slave.sv | 191 +++++++++++++++++++
 tb/tb_spi_regfile_slave.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// -----------------------------------------------------------------------------
// spi_regfile_pkg
// Shared types and helpers for the parallel-lane SPI register-file slave.
//   state_e  : frame FSM states (CMD is only a name; the command is consumed
//              on the IDLE edge, so CMD is never actually entered)
//   RW_BIT   : command-beat bit that selects read (1) or write (0)
//   INC_BIT  : command-beat bit that enables pointer auto-increment
//   is_ro    : tells whether a register address is read-only under a mask
// -----------------------------------------------------------------------------
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    SYNC = 3'd4
  } state_e;

  // Widest read-only mask the is_ro helper accepts (256 registers).
  localparam int unsigned MASK_MAX   = 256;
  localparam int unsigned MASK_IDX_W = 8;

  function automatic int unsigned RW_BIT(input int unsigned busWidth);
    return busWidth - 1;
  endfunction

  function automatic int unsigned INC_BIT(input int unsigned busWidth);
    return busWidth - 2;
  endfunction

  function automatic logic is_ro(input int unsigned addr,
                                 input logic [MASK_MAX-1:0] mask);
    logic result;
    result = 1'b0;
    if (addr < MASK_MAX) begin
      result = mask[addr[MASK_IDX_W-1:0]];
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_regfile_slave_if.sv
// -----------------------------------------------------------------------------
// spi_regfile_slave_if
// Parallel-lane SPI bus between the host (master) and the register-file slave.
//   cs_n : frame select, active low
//   mosi : BUS_WIDTH-wide data from host
//   miso : BUS_WIDTH-wide data to host
// -----------------------------------------------------------------------------
interface spi_regfile_slave_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 cs_n;
  logic [BUS_WIDTH-1:0] mosi;
  logic [BUS_WIDTH-1:0] miso;

  modport master (output cs_n, output mosi, input miso);
  modport slave  (input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_regfile_mem.sv
// -----------------------------------------------------------------------------
// spi_regfile_mem
// Register array behind the SPI slave.
//   clk, rst : clock and synchronous active-high reset (clears all storage)
//   we       : write enable; the caller only asserts it for writable slots
//   waddr    : write address
//   wdata    : write data
//   raddr    : combinational read address
//   rdata    : read data at raddr (read-only slots return ro_in)
//   ro_in    : flat values for the read-only slots, slice i = register i
//   regs_q   : flat view of every register, read-only slots show ro_in
// -----------------------------------------------------------------------------
module spi_regfile_mem #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [(2**ADDR_WIDTH)-1:0] RO_MASK = 'h0001
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   we,
  input  logic [ADDR_WIDTH-1:0]                  waddr,
  input  logic [BUS_WIDTH-1:0]                   wdata,
  input  logic [ADDR_WIDTH-1:0]                  raddr,
  output logic [BUS_WIDTH-1:0]                   rdata,
  input  logic [(2**ADDR_WIDTH)*BUS_WIDTH-1:0]   ro_in,
  output logic [(2**ADDR_WIDTH)*BUS_WIDTH-1:0]   regs_q
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [BUS_WIDTH-1:0] mem_q [NUM_REGS];
  logic [BUS_WIDTH-1:0] view  [NUM_REGS];

  // Storage for the writable slots. Read-only slots are never written, so
  // their flops stay at zero and fall away in synthesis.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Substitute the fabric value for read-only slots so that both the host
  // read path and the flat fabric view see ro_in live.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = RO_MASK[i] ? ro_in[i*BUS_WIDTH +: BUS_WIDTH] : mem_q[i];
    end
  end

  // Flatten the register view and serve the read port.
  always_comb begin
    regs_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_q[i*BUS_WIDTH +: BUS_WIDTH] = view[i];
    end
    rdata = view[raddr];
  end

endmodule

// File: rtl/spi_regfile_slave.sv
// -----------------------------------------------------------------------------
// spi_regfile_slave
// Frame-based register-file slave on a parallel MOSI/MISO bus clocked by sclk.
// The first beat of a frame is a command {rw, inc, .., addr}; the remaining
// beats are burst data written to or read from the register file.
//   clk        : system clock, doubles as sclk
//   rst        : synchronous active-high reset
//   spi        : slave modport carrying cs_n, mosi and registered miso
//   ro_in      : values for the read-only registers, slice i = register i
//   regs_q     : flat view of the register file
//   wr_stb     : one-cycle pulse per accepted write
//   wr_addr    : address of that write
//   wr_data    : data of that write
//   busy       : high while a frame is in progress
//   frame_done : one-cycle pulse on the first cycle cs_n is high after a frame
// -----------------------------------------------------------------------------
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [(2**ADDR_WIDTH)-1:0] RO_MASK = 'h0001
) (
  input  logic                                 clk,
  input  logic                                 rst,
  spi_regfile_slave_if.slave                   spi,
  input  logic [(2**ADDR_WIDTH)*BUS_WIDTH-1:0] ro_in,
  output logic [(2**ADDR_WIDTH)*BUS_WIDTH-1:0] regs_q,
  output logic                                 wr_stb,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [BUS_WIDTH-1:0]                 wr_data,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int RwBit  = int'(RW_BIT(BUS_WIDTH));
  localparam int IncBit = int'(INC_BIT(BUS_WIDTH));

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > BUS_WIDTH - 2) begin : gBadAddrWidth
    $error("spi_regfile_slave: ADDR_WIDTH must lie in 1..BUS_WIDTH-2");
  end
  if ((2 ** ADDR_WIDTH) > MASK_MAX) begin : gBadRegCount
    $error("spi_regfile_slave: register count exceeds the read-only mask helper");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  inc_q, inc_d;
  logic [BUS_WIDTH-1:0]  miso_q, miso_d;
  logic                  wrStb_q, wrStb_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [BUS_WIDTH-1:0]  wrData_q, wrData_d;
  logic                  busy_q, busy_d;
  logic                  frameDone_q, frameDone_d;

  logic                  memWe;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [BUS_WIDTH-1:0]  rdData;
  logic [ADDR_WIDTH-1:0] cmdAddr;
  logic                  cmdRead;
  logic                  cmdInc;
  logic                  ptrIsRo;

  assign cmdAddr = spi.mosi[ADDR_WIDTH-1:0];
  assign cmdRead = spi.mosi[RwBit];
  assign cmdInc  = spi.mosi[IncBit];
  assign ptrIsRo = is_ro(32'(ptr_q), MASK_MAX'(RO_MASK));

  // On the command edge the read has to come from the address inside the
  // beat itself so that data appears one cycle after the command.
  assign rdAddr = (state_q == IDLE) ? cmdAddr : ptr_q;

  spi_regfile_mem #(
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RO_MASK   (RO_MASK)
  ) uMem (
    .clk   (clk),
    .rst   (rst),
    .we    (memWe),
    .waddr (ptr_q),
    .wdata (spi.mosi),
    .raddr (rdAddr),
    .rdata (rdData),
    .ro_in (ro_in),
    .regs_q(regs_q)
  );

  // Frame sequencing: decode the command in IDLE, then stream burst beats
  // until cs_n rises. A reset that lands mid-frame parks us in SYNC until
  // the host closes that frame, so its leftover beats are never decoded.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    inc_d       = inc_q;
    miso_d      = miso_q;
    memWe       = 1'b0;
    wrStb_d     = 1'b0;
    wrAddr_d    = '0;
    wrData_d    = '0;
    frameDone_d = 1'b0;

    case (state_q)
      SYNC: begin
        if (spi.cs_n) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!spi.cs_n) begin
          inc_d = cmdInc;
          if (cmdRead) begin
            state_d = RD;
            miso_d  = rdData;
            ptr_d   = cmdAddr + ADDR_WIDTH'(cmdInc);
          end else begin
            state_d = WR;
            ptr_d   = cmdAddr;
          end
        end
      end

      WR: begin
        if (spi.cs_n) begin
          state_d     = IDLE;
          miso_d      = '0;
          frameDone_d = 1'b1;
        end else begin
          if (!ptrIsRo) begin
            memWe    = 1'b1;
            wrStb_d  = 1'b1;
            wrAddr_d = ptr_q;
            wrData_d = spi.mosi;
          end
          ptr_d = ptr_q + ADDR_WIDTH'(inc_q);
        end
      end

      RD: begin
        if (spi.cs_n) begin
          state_d     = IDLE;
          miso_d      = '0;
          frameDone_d = 1'b1;
        end else begin
          miso_d = rdData;
          ptr_d  = ptr_q + ADDR_WIDTH'(inc_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == WR) || (state_d == RD);
  end

  // State and output registers. Reset wins over any beat on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= spi.cs_n ? IDLE : SYNC;
      ptr_q       <= '0;
      inc_q       <= 1'b0;
      miso_q      <= '0;
      wrStb_q     <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      inc_q       <= inc_d;
      miso_q      <= miso_d;
      wrStb_q     <= wrStb_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign spi.miso   = miso_q;
  assign wr_stb     = wrStb_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile_slave
// Self-checking bench for spi_regfile_slave (BUS_WIDTH 8, ADDR_WIDTH 4,
// register 0 read-only). A frame-level reference model tracks the register
// contents and the expected bus/fabric outputs every cycle.
// -----------------------------------------------------------------------------
module tb_spi_regfile_slave;

  localparam int BW = 8;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0001;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*BW-1:0] roIn;
  logic [NR*BW-1:0] regsQ;
  logic             wrStb;
  logic [AW-1:0]    wrAddr;
  logic [BW-1:0]    wrData;
  logic             busy;
  logic             frameDone;

  spi_regfile_slave_if #(.BUS_WIDTH(BW)) spiBus ();

  spi_regfile_slave #(
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .RO_MASK   (RO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spiBus),
    .ro_in     (roIn),
    .regs_q    (regsQ),
    .wr_stb    (wrStb),
    .wr_addr   (wrAddr),
    .wr_data   (wrData),
    .busy      (busy),
    .frame_done(frameDone)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int stbSeen = 0;
  int fdSeen  = 0;

  // Reference model state: register contents plus where we are in a frame.
  logic [BW-1:0] mRegs [NR];
  bit            inFrame  = 1'b0;
  bit            waitHigh = 1'b0;
  bit            isRead   = 1'b0;
  bit            mInc     = 1'b0;
  int            mPtr     = 0;
  logic [BW-1:0] mMiso    = '0;
  bit            mStb     = 1'b0;
  int            mWa      = 0;
  logic [BW-1:0] mWd      = '0;
  bit            mBusy    = 1'b0;
  bit            mFd      = 1'b0;

  typedef struct {
    bit            csN;
    logic [BW-1:0] mosi;
    logic [BW-1:0] expMiso;
    bit            expStb;
    logic [AW-1:0] expAddr;
    logic [BW-1:0] expData;
    bit            expBusy;
    bit            expFd;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [BW-1:0] readReg(input int a);
    return RO[a] ? roIn[a*BW +: BW] : mRegs[a];
  endfunction

  function automatic logic [NR*BW-1:0] expView();
    logic [NR*BW-1:0] v;
    for (int i = 0; i < NR; i++) begin
      v[i*BW +: BW] = readReg(i);
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the frame rules.
  task automatic modelEdge(input bit r, input bit cs, input logic [BW-1:0] d);
    int a;
    mStb = 1'b0;
    mFd  = 1'b0;
    mWa  = 0;
    mWd  = '0;
    if (r) begin
      for (int i = 0; i < NR; i++) mRegs[i] = '0;
      inFrame  = 1'b0;
      waitHigh = !cs;
      mPtr     = 0;
      mInc     = 1'b0;
      mMiso    = '0;
    end else if (waitHigh) begin
      if (cs) waitHigh = 1'b0;
    end else if (!inFrame) begin
      if (!cs) begin
        inFrame = 1'b1;
        isRead  = d[BW-1];
        mInc    = d[BW-2];
        a       = int'(d[AW-1:0]);
        if (isRead) begin
          mMiso = readReg(a);
          mPtr  = (a + int'(mInc)) % NR;
        end else begin
          mPtr = a;
        end
      end
    end else if (cs) begin
      inFrame = 1'b0;
      mMiso   = '0;
      mFd     = 1'b1;
    end else if (isRead) begin
      mMiso = readReg(mPtr);
      mPtr  = (mPtr + int'(mInc)) % NR;
    end else begin
      if (!RO[mPtr]) begin
        mRegs[mPtr] = d;
        mStb        = 1'b1;
        mWa         = mPtr;
        mWd         = d;
      end
      mPtr = (mPtr + int'(mInc)) % NR;
    end
    mBusy = inFrame;
  endtask

  // Drive one beat, clock it, then compare every output with the model.
  task automatic applyStimulus(input bit r, input bit cs, input logic [BW-1:0] d);
    rst         = r;
    spiBus.cs_n = cs;
    spiBus.mosi = d;
    @(posedge clk);
    modelEdge(r, cs, d);
    #1;
    if (wrStb === 1'b1) stbSeen++;
    if (frameDone === 1'b1) fdSeen++;
    checkOutput("miso", spiBus.miso, mMiso);
    checkOutput("wr_stb", wrStb, mStb);
    checkOutput("busy", busy, mBusy);
    checkOutput("frame_done", frameDone, mFd);
    checkOutput("regs_q", regsQ, expView());
    if (mStb) begin
      checkOutput("wr_addr", wrAddr, mWa);
      checkOutput("wr_data", wrData, mWd);
    end
  endtask

  initial begin
    int s0;
    int f0;
    for (int i = 0; i < NR; i++) mRegs[i] = '0;
    rst         = 1'b1;
    spiBus.cs_n = 1'b1;
    spiBus.mosi = '0;
    roIn        = '0;

    // Reset values
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("reset miso", spiBus.miso, 0);
    checkOutput("reset wr_stb", wrStb, 0);
    checkOutput("reset wr_addr", wrAddr, 0);
    checkOutput("reset wr_data", wrData, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_done", frameDone, 0);
    checkOutput("reset regs_q", regsQ, 0);

    // Write burst with wrap over the read-only slot, then read it back
    vecs[0]  = '{1'b0, 8'h4E, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'hAA, 8'h00, 1'b1, 4'hE, 8'hAA, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'hBB, 8'h00, 1'b1, 4'hF, 8'hBB, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'hCC, 8'h00, 1'b1, 4'h1, 8'hCC, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'hCF, 8'hBB, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h5A, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'hCC, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    roIn[7:0] = 8'h5A;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, vecs[i].csN, vecs[i].mosi);
      checkOutput($sformatf("vec%0d miso", i), spiBus.miso, vecs[i].expMiso);
      checkOutput($sformatf("vec%0d wr_stb", i), wrStb, vecs[i].expStb);
      checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d frame_done", i), frameDone, vecs[i].expFd);
      if (vecs[i].expStb) begin
        checkOutput($sformatf("vec%0d wr_addr", i), wrAddr, vecs[i].expAddr);
        checkOutput($sformatf("vec%0d wr_data", i), wrData, vecs[i].expData);
      end
    end
    checkOutput("burst reg14", regsQ[14*BW +: BW], 8'hAA);
    checkOutput("burst reg15", regsQ[15*BW +: BW], 8'hBB);
    checkOutput("burst reg1", regsQ[1*BW +: BW], 8'hCC);

    // No-increment write: both beats land on register 3
    s0 = stbSeen;
    applyStimulus(1'b0, 1'b0, 8'h03);
    applyStimulus(1'b0, 1'b0, 8'h11);
    applyStimulus(1'b0, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("noinc reg3", regsQ[3*BW +: BW], 8'h22);
    checkOutput("noinc strobes", stbSeen - s0, 2);

    // Reset mid-frame: the rest of the frame is ignored until cs_n rises
    applyStimulus(1'b0, 1'b0, 8'h05);
    applyStimulus(1'b0, 1'b0, 8'h99);
    applyStimulus(1'b1, 1'b0, 8'h77);
    s0 = stbSeen;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h77);
    checkOutput("sync strobes", stbSeen - s0, 0);
    checkOutput("sync busy", busy, 0);
    checkOutput("sync reg5", regsQ[5*BW +: BW], 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 8'h5C);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("resume reg2", regsQ[2*BW +: BW], 8'h5C);
    checkOutput("resume strobes", stbSeen - s0, 1);

    // Command-only frame followed immediately by a write frame
    s0 = stbSeen;
    f0 = fdSeen;
    applyStimulus(1'b0, 1'b0, 8'h82);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("cmdonly frame_done", frameDone, 1);
    checkOutput("cmdonly strobes", stbSeen - s0, 0);
    applyStimulus(1'b0, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("b2b reg2", regsQ[2*BW +: BW], 8'h3C);
    checkOutput("b2b frames", fdSeen - f0, 2);

    // Randomised frames, reads, writes and occasional resets
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) roIn = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                    BW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
